// File: rtl/multi_pwm_dimmer_pkg.sv
// Shared types, defaults and helpers for the multi-channel button PWM dimmer.
package multi_pwm_dimmer_pkg;

  localparam int unsigned LVL_W_DEF = 7;
  localparam int unsigned DIV_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_pwm_dimmer_if.sv
// Board-side bundle of the dimmer: three active-low buttons in, LED bar, PWM LEDs and channel index out.
interface multi_pwm_dimmer_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LVL_W  = 7,
  parameter int unsigned CH_W   = multi_pwm_dimmer_pkg::clog2_min1(NUM_CH)
);

  logic              button_up_n;
  logic              button_dn_n;
  logic              button_sel_n;
  logic [LVL_W-1:0]  led;
  logic [NUM_CH-1:0] pwm_led;
  logic [CH_W-1:0]   ch_sel;

  modport slave (
    input  button_up_n,
    input  button_dn_n,
    input  button_sel_n,
    output led,
    output pwm_led,
    output ch_sel
  );

  modport master (
    output button_up_n,
    output button_dn_n,
    output button_sel_n,
    input  led,
    input  pwm_led,
    input  ch_sel
  );

endinterface

// File: rtl/multi_pwm_dimmer_hold_repeat.sv
// One button conditioner: 2-FF synchroniser and a tick-paced hold / auto-repeat
// state machine that emits single-cycle step strobes coincident with tick.
module multi_pwm_dimmer_hold_repeat
  import multi_pwm_dimmer_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic step_c
);

  localparam int unsigned HCNT_W = clog2_min1(HOLD_TICKS + 1);

  logic              meta_q;
  logic              pressed_q;
  hold_state_t       state_q;
  hold_state_t       state_d;
  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] hcnt_d;

  // Synchroniser held in pressed polarity; the reset value means released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      meta_q    <= ~btn_n_i;
      pressed_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (pressed_q) begin
            state_d = HOLD;
            hcnt_d  = HCNT_W'(1);
          end
        end
        HOLD: begin
          if (!pressed_q) begin
            state_d = IDLE;
          end else if (hcnt_q == HCNT_W'(HOLD_TICKS)) begin
            state_d = REPEAT;
          end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end
        end
        REPEAT: begin
          if (!pressed_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A step fires on the first pressed tick and on every tick while repeating.
  always_comb begin
    step_c = 1'b0;
    if (tick_i && pressed_q && (state_q == IDLE || state_q == REPEAT)) step_c = 1'b1;
  end

  assign pressed_o = pressed_q;

endmodule

// File: rtl/multi_pwm_dimmer.sv
// Multi-channel LED dimmer: up/down/select buttons set per-channel levels driving
// first-order accumulator PWM. Build option MULTI_PWM_DIMMER_WRAP_EN wraps levels instead of saturating.
module multi_pwm_dimmer
  import multi_pwm_dimmer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned LVL_W      = LVL_W_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned HOLD_TICKS = 7,
  parameter int unsigned DISP_TICKS = 63
) (
  input logic               clk_50mhz,
  input logic               rst_n,
  multi_pwm_dimmer_if.slave bus
);

  localparam int unsigned CH_W   = clog2_min1(NUM_CH);
  localparam int unsigned DISP_W = clog2_min1(DISP_TICKS + 1);

  logic [DIV_W-1:0]  presc_q;
  logic              tick_c;
  logic              sel_meta_q;
  logic              sel_pressed_q;
  logic              sel_prev_q;
  logic              sel_edge_c;
  logic              up_pressed_c;
  logic              dn_pressed_c;
  logic              up_step_c;
  logic              dn_step_c;
  logic [CH_W-1:0]   ch_sel_q;
  logic [DISP_W-1:0] disp_q;
  logic [LVL_W-1:0]  level_q [NUM_CH];
  logic [LVL_W-1:0]  lvl_cur_c;
  logic [LVL_W-1:0]  lvl_new_c;
  logic [NUM_CH-1:0] pwm_n_c;
  logic [LVL_W-1:0]  led_q;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_q + DIV_W'(1);
  end

  assign tick_c = &presc_q;

  multi_pwm_dimmer_hold_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_up (
    .clk       (clk_50mhz),
    .rst_n     (rst_n),
    .tick_i    (tick_c),
    .btn_n_i   (bus.button_up_n),
    .pressed_o (up_pressed_c),
    .step_c    (up_step_c)
  );

  multi_pwm_dimmer_hold_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_dn (
    .clk       (clk_50mhz),
    .rst_n     (rst_n),
    .tick_i    (tick_c),
    .btn_n_i   (bus.button_dn_n),
    .pressed_o (dn_pressed_c),
    .step_c    (dn_step_c)
  );

  // Select button: synchronise, then detect a new press from one tick to the next.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta_q    <= 1'b0;
      sel_pressed_q <= 1'b0;
      sel_prev_q    <= 1'b0;
    end else begin
      sel_meta_q    <= ~bus.button_sel_n;
      sel_pressed_q <= sel_meta_q;
      if (tick_c) sel_prev_q <= sel_pressed_q;
    end
  end

  assign sel_edge_c = tick_c & sel_pressed_q & ~sel_prev_q;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel_q <= '0;
    end else if (sel_edge_c) begin
      ch_sel_q <= (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + CH_W'(1);
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else if (tick_c) begin
      if (up_pressed_c || dn_pressed_c || sel_pressed_q) disp_q <= DISP_W'(DISP_TICKS);
      else if (disp_q != '0)                             disp_q <= disp_q - DISP_W'(1);
    end
  end

  assign lvl_cur_c = level_q[ch_sel_q];

  // Opposing steps in the same tick cancel; the step lands on the pre-select channel.
  always_comb begin
    lvl_new_c = lvl_cur_c;
    if (up_step_c && !dn_step_c) begin
`ifdef MULTI_PWM_DIMMER_WRAP_EN
      lvl_new_c = lvl_cur_c + LVL_W'(1);
`else
      if (!(&lvl_cur_c)) lvl_new_c = lvl_cur_c + LVL_W'(1);
`endif
    end else if (dn_step_c && !up_step_c) begin
`ifdef MULTI_PWM_DIMMER_WRAP_EN
      lvl_new_c = lvl_cur_c - LVL_W'(1);
`else
      if (|lvl_cur_c) lvl_new_c = lvl_cur_c - LVL_W'(1);
`endif
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) level_q[i] <= '0;
    end else if (up_step_c ^ dn_step_c) begin
      level_q[ch_sel_q] <= lvl_new_c;
    end
  end

  // Per-channel accumulator; the carry out of each add is the PWM on-pulse.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_pwm
    logic [LVL_W-1:0] acc_q;
    logic             pwm_n_q;
    logic [LVL_W:0]   sum_c;

    assign sum_c = {1'b0, acc_q} + {1'b0, level_q[g]};

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
        acc_q   <= '0;
        pwm_n_q <= 1'b1;
      end else begin
        acc_q   <= sum_c[LVL_W-1:0];
        pwm_n_q <= ~sum_c[LVL_W];
      end
    end

    assign pwm_n_c[g] = pwm_n_q;
  end

  // Bar shows the selected level while the display timer runs, else mirrors its PWM.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n)             led_q <= '1;
    else if (disp_q != '0)  led_q <= ~lvl_cur_c;
    else                    led_q <= {LVL_W{pwm_n_c[ch_sel_q]}};
  end

  assign bus.led     = led_q;
  assign bus.pwm_led = pwm_n_c;
  assign bus.ch_sel  = ch_sel_q;

endmodule

// File: tb/tb_multi_pwm_dimmer.sv
// Scoreboard bench for multi_pwm_dimmer: tick-level behavioural model feeds an expectation queue
// consumed by an independent monitor. Honours MULTI_PWM_DIMMER_WRAP_EN for the limit behaviour.
module tb_multi_pwm_dimmer;
  import multi_pwm_dimmer_pkg::*;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned LVL_W      = 7;
  localparam int unsigned DIV_W      = 3;
  localparam int unsigned HOLD_TICKS = 3;
  localparam int unsigned DISP_TICKS = 5;
  localparam int LMAX = (1 << LVL_W) - 1;
  localparam int TP   = 1 << DIV_W;

  typedef struct {
    int                     due;
    bit                     win;
    int                     sel;
    int                     lvl;
    bit                     disp_on;
    logic [NUM_CH-1:0][7:0] wl;
  } exp_t;

  logic clk_50mhz = 1'b0;
  logic rst_n     = 1'b1;
  int   cyc;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  // Reference model state, advanced once per tick.
  int lvl [NUM_CH];
  int sel;
  int hu;
  int hd;
  int disp;
  bit sel_prev;

  multi_pwm_dimmer_if #(.NUM_CH(NUM_CH), .LVL_W(LVL_W)) bus ();

  multi_pwm_dimmer #(
    .NUM_CH     (NUM_CH),
    .LVL_W      (LVL_W),
    .DIV_W      (DIV_W),
    .HOLD_TICKS (HOLD_TICKS),
    .DISP_TICKS (DISP_TICKS)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  always @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endfunction

  function automatic int bump(input int v, input int d);
`ifdef MULTI_PWM_DIMMER_WRAP_EN
    return (v + d + LMAX + 1) % (LMAX + 1);
`else
    if (v + d > LMAX || v + d < 0) return v;
    return v + d;
`endif
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) lvl[c] = 0;
    sel = 0; hu = 0; hd = 0; disp = 0; sel_prev = 1'b0;
  endfunction

  // A button held for n ticks steps at n==1 and from n==HOLD_TICKS+2 onwards.
  function automatic void model_tick(input bit up, input bit dn, input bit sl);
    bit su;
    bit sd;
    hu = up ? hu + 1 : 0;
    hd = dn ? hd + 1 : 0;
    su = up && (hu == 1 || hu >= HOLD_TICKS + 2);
    sd = dn && (hd == 1 || hd >= HOLD_TICKS + 2);
    if (su && !sd) lvl[sel] = bump(lvl[sel], 1);
    if (sd && !su) lvl[sel] = bump(lvl[sel], -1);
    if (sl && !sel_prev) sel = (sel + 1) % NUM_CH;
    sel_prev = sl;
    if (up || dn || sl) disp = DISP_TICKS;
    else if (disp > 0)  disp = disp - 1;
  endfunction

  // Called at the negedge two clocks after a tick edge; covers exactly one tick period.
  task automatic period(input bit up, input bit dn, input bit sl, input bit push);
    exp_t e;
    bus.button_up_n  = ~up;
    bus.button_dn_n  = ~dn;
    bus.button_sel_n = ~sl;
    model_tick(up, dn, sl);
    if (push) begin
      e.due     = cyc + TP + 1;
      e.win     = 1'b0;
      e.sel     = sel;
      e.lvl     = lvl[sel];
      e.disp_on = (disp != 0);
      e.wl      = '0;
      exp_q.push_back(e);
    end
    repeat (TP) @(negedge clk_50mhz);
  endtask

  task automatic align();
    for (int i = 0; i < 2 * TP && (cyc % TP) != 2; i++) @(negedge clk_50mhz);
    if ((cyc % TP) != 2) chk("align", cyc % TP, 2);
  endtask

  task automatic window_check();
    exp_t e;
    repeat (DISP_TICKS + 1) period(1'b0, 1'b0, 1'b0, 1'b1);
    e.due     = cyc + 1;
    e.win     = 1'b1;
    e.sel     = sel;
    e.lvl     = lvl[sel];
    e.disp_on = (disp != 0);
    for (int c = 0; c < NUM_CH; c++) e.wl[c] = 8'(lvl[c]);
    exp_q.push_back(e);
    repeat (17) period(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_window(input exp_t e);
    int lows [NUM_CH];
    int led_on;
    int led_bad;
    led_on = 0;
    led_bad = 0;
    for (int c = 0; c < NUM_CH; c++) lows[c] = 0;
    for (int n = 0; n <= LMAX; n++) begin
      for (int c = 0; c < NUM_CH; c++) if (bus.pwm_led[c] == 1'b0) lows[c]++;
      if (bus.led == '0)      led_on++;
      else if (bus.led != '1) led_bad++;
      @(negedge clk_50mhz);
    end
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("pwm_on_count_ch%0d", c), lows[c], int'(e.wl[c]));
    if (!e.disp_on) begin
      chk("led_mirror_count", led_on, e.lvl);
      chk("led_mirror_uniform", led_bad, 0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_50mhz);
      while (rst_n && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        if (e.due < cyc) begin
          chk("sample_missed", cyc, e.due);
        end else if (e.win) begin
          run_window(e);
        end else begin
          chk("ch_sel", int'(bus.ch_sel), e.sel);
          if (e.disp_on) chk("led_level", int'(bus.led), LMAX - e.lvl);
        end
      end
    end
  end

  initial begin : stim
    bit u;
    bit d;
    bit s;
    bus.button_up_n  = 1'b1;
    bus.button_dn_n  = 1'b1;
    bus.button_sel_n = 1'b1;
    model_reset();

    // Reset asserted between clock edges must act immediately.
    #5 rst_n = 1'b0;
    #1;
    chk("rst_led", int'(bus.led), LMAX);
    chk("rst_pwm", int'(bus.pwm_led), (1 << NUM_CH) - 1);
    chk("rst_ch_sel", int'(bus.ch_sel), 0);
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;
    align();

    // Hold up for ten ticks, then let the display time out.
    repeat (10) period(1'b1, 1'b0, 1'b0, 1'b1);
    window_check();

    // Raise channel 0 to 32.
    for (int i = 0; i < 64 && lvl[0] != 32; i++) period(1'b1, 1'b0, 1'b0, 1'b1);
    window_check();

    // Five select presses, then a step coincident with a select edge.
    for (int i = 0; i < 5; i++) begin
      period(1'b0, 1'b0, 1'b1, 1'b1);
      period(1'b0, 1'b0, 1'b0, 1'b1);
    end
    period(1'b1, 1'b0, 1'b1, 1'b1);
    period(1'b0, 1'b0, 1'b0, 1'b1);
    window_check();

    // Up and down together cancel.
    repeat (6) period(1'b1, 1'b1, 1'b0, 1'b1);
    period(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomised button activity with sticky button states.
    u = 1'b0; d = 1'b0; s = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(3) == 0) u = ~u;
      if ($urandom_range(4) == 0) d = ~d;
      if ($urandom_range(5) == 0) s = ~s;
      period(u, d, s, 1'b1);
    end
    window_check();

    // Upper and lower limits on the selected channel.
    for (int i = 0; i < 300 && lvl[sel] != LMAX; i++) period(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) period(1'b1, 1'b0, 1'b0, 1'b1);
    period(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300 && lvl[sel] != 0; i++) period(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) period(1'b0, 1'b1, 1'b0, 1'b1);
    window_check();

    // Reset during auto-repeat with the button kept held across release.
    repeat (8) period(1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    #3 rst_n = 1'b0;
    #1;
    chk("rst2_led", int'(bus.led), LMAX);
    chk("rst2_pwm", int'(bus.pwm_led), (1 << NUM_CH) - 1);
    chk("rst2_ch_sel", int'(bus.ch_sel), 0);
    model_reset();
    repeat (2) @(negedge clk_50mhz);
    rst_n = 1'b1;
    align();
    repeat (7) period(1'b1, 1'b0, 1'b0, 1'b1);
    window_check();

    for (int i = 0; i < 4 * TP && exp_q.size() != 0; i++) @(negedge clk_50mhz);
    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
